mem_ctrl_wide: RTL

- Parametrised successor to the byte-wide memory controller.
- Accepts byte, halfword and word CPU accesses, decodes the address into an external 16-bit async SRAM, a byte-wide SD buffer window, or unmapped space.
- Splits wide accesses into SRAM halfword beats or SD byte beats.
- Adds configurable SRAM wait states, alignment/unmapped/timeout error reporting and an explicit completion pulse.
- Sits between the CPU load/store unit and board I/O pins.

---
 rtl/mem_ctrl_wide.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl_wide.sv
// mem_ctrl_wide: CPU load/store front end for a 16-bit async SRAM and a
// byte-wide SD buffer window.
//   addr[31:21]==0 -> SRAM (halfword beats), ==1 -> SD window (byte beats),
//   anything else, misaligned, oversize, size=3 or read+write -> err pulse.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   addr/size/wdata/req_*        request, sampled while ready=1
//   ready/done/err/rdata         status, one-cycle done/err pulses, read data
//   sram_addr/sram_dq_*/sram_*_n SRAM pins (dq tristate is resolved above)
//   sd_addr/sd_in/sd_out/sd_write/sd_read/sd_ready  SD buffer handshake
module mem_ctrl_wide #(
  parameter int unsigned CPU_DW      = 32,
  parameter int unsigned SRAM_AW     = 20,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned SD_AW       = 10,
  parameter int unsigned SD_TIMEOUT  = 1023
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        addr,
  input  logic [1:0]         size,
  input  logic [CPU_DW-1:0]  wdata,
  input  logic               req_write,
  input  logic               req_read,
  output logic               ready,
  output logic               done,
  output logic               err,
  output logic [CPU_DW-1:0]  rdata,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               sram_lb_n,
  output logic               sram_ub_n,
  output logic [SD_AW-1:0]   sd_addr,
  output logic [7:0]         sd_in,
  input  logic [7:0]         sd_out,
  output logic               sd_write,
  output logic               sd_read,
  input  logic               sd_ready
);

  localparam int unsigned TW = (SD_TIMEOUT > 1) ? $clog2(SD_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE, SRAM_STROBE, SRAM_GAP, SD_ISSUE, SD_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic               is_wr_q, is_wr_d;
  logic [1:0]         size_q, size_d;
  logic               lane_q, lane_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rbuf_q, rbuf_d;
  logic [1:0]         idx_q, idx_d;
  logic [2:0]         wcnt_q, wcnt_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [CPU_DW-1:0]  rdata_q, rdata_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [SD_AW-1:0]   sd_addr_q, sd_addr_d;

  logic bad_req;
  logic sd_last;

  always_comb begin
    bad_req = (req_read & req_write)
            | (size == 2'd3)
            | ((size == 2'd1) && (CPU_DW < 16))
            | ((size == 2'd2) && (CPU_DW < 32))
            | ((size == 2'd1) && addr[0])
            | ((size == 2'd2) && (addr[1:0] != 2'b00))
            | (addr[31:22] != '0);
    // last byte index is 0/1/3 for byte/half/word
    sd_last = (idx_q == {size_q[1], |size_q});
  end

  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    size_d      = size_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    idx_d       = idx_q;
    wcnt_d      = wcnt_q;
    tcnt_d      = tcnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    sram_addr_d = sram_addr_q;
    sd_addr_d   = sd_addr_q;
    unique case (state_q)
      IDLE: begin
        if (req_read | req_write) begin
          if (bad_req) begin
            err_d = 1'b1;
          end else begin
            is_wr_d = req_write;
            size_d  = size;
            lane_d  = addr[0];
            wdata_d = 32'(wdata);
            rbuf_d  = '0;
            idx_d   = '0;
            wcnt_d  = '0;
            tcnt_d  = '0;
            if (addr[21]) begin
              sd_addr_d = addr[SD_AW-1:0];
              state_d   = SD_ISSUE;
            end else begin
              sram_addr_d = addr[SRAM_AW:1];
              state_d     = SRAM_STROBE;
            end
          end
        end
      end
      SRAM_STROBE: begin
        if (wcnt_q == 3'(WAIT_CYCLES)) begin
          state_d = SRAM_GAP;
          wcnt_d  = '0;
          if (!is_wr_q) begin
            if (size_q == 2'd0)
              rbuf_d[7:0] = lane_q ? sram_dq_i[15:8] : sram_dq_i[7:0];
            else if (idx_q[0])
              rbuf_d[31:16] = sram_dq_i;
            else
              rbuf_d[15:0] = sram_dq_i;
          end
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      SRAM_GAP: begin
        // only a word access has a second beat
        if (idx_q[0] == size_q[1]) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (!is_wr_q) rdata_d = rbuf_q[CPU_DW-1:0];
        end else begin
          idx_d       = idx_q + 2'd1;
          sram_addr_d = sram_addr_q + SRAM_AW'(1);
          state_d     = SRAM_STROBE;
        end
      end
      SD_ISSUE: begin
        state_d = SD_WAIT;
        tcnt_d  = '0;
      end
      SD_WAIT: begin
        if (sd_ready) begin
          if (!is_wr_q) rbuf_d[{idx_q, 3'b000} +: 8] = sd_out;
          if (sd_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (!is_wr_q) rdata_d = rbuf_d[CPU_DW-1:0];
          end else begin
            idx_d     = idx_q + 2'd1;
            sd_addr_d = sd_addr_q + SD_AW'(1);
            state_d   = SD_ISSUE;
          end
        end else if (tcnt_q == TW'(SD_TIMEOUT - 1)) begin
          // abandon the access; partial read bytes stay in rbuf only
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      is_wr_q     <= 1'b0;
      size_q      <= '0;
      lane_q      <= 1'b0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      idx_q       <= '0;
      wcnt_q      <= '0;
      tcnt_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      sd_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      tcnt_q      <= tcnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      sd_addr_q   <= sd_addr_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    ready      = (state_q == IDLE);
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_lb_n  = 1'b1;
    sram_ub_n  = 1'b1;
    sram_dq_oe = 1'b0;
    sram_dq_o  = '0;
    sd_read    = 1'b0;
    sd_write   = 1'b0;
    sd_in      = '0;
    if (state_q == SRAM_STROBE) begin
      sram_we_n  = !is_wr_q;
      sram_oe_n  = is_wr_q;
      sram_dq_oe = is_wr_q;
      if (size_q == 2'd0) begin
        sram_lb_n = lane_q;
        sram_ub_n = !lane_q;
      end else begin
        sram_lb_n = 1'b0;
        sram_ub_n = 1'b0;
      end
      if (is_wr_q) begin
        if (size_q == 2'd0)
          sram_dq_o = lane_q ? {wdata_q[7:0], 8'h00} : {8'h00, wdata_q[7:0]};
        else
          sram_dq_o = idx_q[0] ? wdata_q[31:16] : wdata_q[15:0];
      end
    end
    if (state_q == SD_ISSUE) begin
      sd_read  = !is_wr_q;
      sd_write = is_wr_q;
      if (is_wr_q) sd_in = wdata_q[{idx_q, 3'b000} +: 8];
    end
  end

  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign sram_addr = sram_addr_q;
  assign sd_addr   = sd_addr_q;

endmodule
